// File: rtl/param_mux_rr_if.sv
// Handshake bundle between N producers, the shared mux and its single consumer.
// The producer/consumer side takes the master modport, the mux takes the slave modport.
interface param_mux_rr_if #(
    parameter int WIDTH = 4,
    parameter int NCH   = 4
);
    localparam int SELW = $clog2(NCH);

    logic [NCH*WIDTH-1:0] in_data;
    logic [NCH-1:0]       in_valid;
    logic [NCH-1:0]       in_ready;
    logic                 mode;
    logic [SELW-1:0]      sel;
    logic [WIDTH-1:0]     out_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [SELW-1:0]      out_ch;

    modport master (
        output in_data, in_valid, mode, sel, out_ready,
        input  in_ready, out_data, out_valid, out_ch
    );

    modport slave (
        input  in_data, in_valid, mode, sel, out_ready,
        output in_ready, out_data, out_valid, out_ch
    );
endinterface

// File: rtl/param_mux_rr.sv
// N-channel registered mux with valid/ready on every port; manual select or
// round-robin arbitration feeding a single-entry output register.
module param_mux_rr #(
    parameter int WIDTH = 4,
    parameter int NCH   = 4
) (
    input logic           clk,
    input logic           rst,
    param_mux_rr_if.slave bus
);
    localparam int SELW = $clog2(NCH);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t            state_reg, state_next;
    logic [WIDTH-1:0]  data_reg, data_next;
    logic [SELW-1:0]   ch_reg, ch_next;
    logic [SELW-1:0]   last_ch_reg, last_ch_next;

    logic [WIDTH-1:0]  ch_data [NCH];
    logic [NCH-1:0]    man_hit;
    logic              man_valid;
    logic              rr_valid;
    logic [SELW-1:0]   rr_idx;
    logic              grant_valid;
    logic [SELW-1:0]   grant_idx;
    logic              load;

    // Unpack channels; an out-of-range sel matches no channel and never grants.
    for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
        assign ch_data[gi] = bus.in_data[gi*WIDTH +: WIDTH];
        assign man_hit[gi] = bus.in_valid[gi] && (bus.sel == SELW'(gi));
    end

    assign man_valid = |man_hit;

    // Walk offsets from farthest to nearest so the nearest valid channel after
    // last_ch wins without needing an early exit.
    always_comb begin
        int              idx;
        logic [SELW-1:0] idx_s;
        rr_valid = 1'b0;
        rr_idx   = '0;
        idx      = 0;
        idx_s    = '0;
        for (int k = NCH; k >= 1; k--) begin
            idx   = (int'(last_ch_reg) + k) % NCH;
            idx_s = SELW'(idx);
            if (bus.in_valid[idx_s]) begin
                rr_valid = 1'b1;
                rr_idx   = idx_s;
            end
        end
    end

    assign grant_valid = bus.mode ? rr_valid : man_valid;
    assign grant_idx   = bus.mode ? rr_idx   : bus.sel;
    assign load        = (state_reg == EMPTY) || bus.out_ready;

    // in_ready is only ever raised when the word is actually taken this edge.
    for (genvar gi = 0; gi < NCH; gi++) begin : g_ready
        assign bus.in_ready[gi] = !rst && load && grant_valid && (grant_idx == SELW'(gi));
    end

    always_comb begin
        state_next   = state_reg;
        data_next    = data_reg;
        ch_next      = ch_reg;
        last_ch_next = last_ch_reg;
        if (load) begin
            if (grant_valid) begin
                state_next   = FULL;
                data_next    = ch_data[grant_idx];
                ch_next      = grant_idx;
                last_ch_next = grant_idx;
            end else begin
                state_next   = EMPTY;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= EMPTY;
            data_reg    <= '0;
            ch_reg      <= '0;
            last_ch_reg <= SELW'(NCH - 1);
        end else begin
            state_reg   <= state_next;
            data_reg    <= data_next;
            ch_reg      <= ch_next;
            last_ch_reg <= last_ch_next;
        end
    end

    assign bus.out_valid = (state_reg == FULL);
    assign bus.out_data  = data_reg;
    assign bus.out_ch    = ch_reg;
endmodule

// File: tb/tb_param_mux_rr.sv
// Scoreboard bench for param_mux_rr: 2-, 3- and 4-channel instances share one
// clock; each scenario task pushes expected words and pops them as they appear.
module tb_param_mux_rr;
    logic clk;
    logic rst;

    param_mux_rr_if #(.WIDTH(4), .NCH(4)) b4 ();
    param_mux_rr_if #(.WIDTH(4), .NCH(2)) b2 ();
    param_mux_rr_if #(.WIDTH(4), .NCH(3)) b3 ();

    param_mux_rr #(.WIDTH(4), .NCH(4)) dut4 (.clk(clk), .rst(rst), .bus(b4));
    param_mux_rr #(.WIDTH(4), .NCH(2)) dut2 (.clk(clk), .rst(rst), .bus(b2));
    param_mux_rr #(.WIDTH(4), .NCH(3)) dut3 (.clk(clk), .rst(rst), .bus(b3));

    typedef struct packed {
        logic [3:0] data;
        logic [1:0] ch;
    } exp_t;

    exp_t sb[$];
    int   total;
    int   bad;
    int   last_m;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1, "watchdog");
    end

    // Reference round-robin pick for the 4-channel instance.
    function automatic int rr_next(input logic [3:0] v, input int last);
        for (int k = 1; k <= 4; k++) begin
            if (v[(last + k) % 4]) return (last + k) % 4;
        end
        return -1;
    endfunction

    function automatic logic [3:0] onehot4(input int g);
        logic [3:0] r;
        r = 4'b0001 << g;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        b4.in_valid = 4'hF;
        b4.mode = 1'b1;
        b4.out_ready = 1'b1;
        tick();
        tick();
        total++;
        if (b4.out_valid !== 1'b0 || b4.out_data !== 4'h0 || b4.out_ch !== 2'd0) begin
            bad++;
            $display("FAIL reset_outputs: got v=%b d=%h ch=%0d want v=0 d=0 ch=0",
                     b4.out_valid, b4.out_data, b4.out_ch);
        end
        total++;
        if (b4.in_ready !== 4'b0000) begin
            bad++;
            $display("FAIL reset_in_ready: got %b want 0000", b4.in_ready);
        end
        total++;
        if (b2.out_valid !== 1'b0 || b3.out_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_small: got v2=%b v3=%b want 0 0", b2.out_valid, b3.out_valid);
        end
        b4.in_valid = 4'h0;
        rst = 1'b0;
        last_m = 3;
        #1;
        $display("txn reset released");
    endtask

    task automatic test_manual();
        exp_t e;
        b2.in_data = 8'b1100_1010;
        b2.in_valid = 2'b11;
        b2.out_ready = 1'b1;
        b2.mode = 1'b0;
        b2.sel = 1'b1;
        #1;
        total++;
        if (b2.in_ready !== 2'b10) begin
            bad++;
            $display("FAIL manual_ready_sel1: got %b want 10", b2.in_ready);
        end
        e.data = 4'b1100; e.ch = 2'd1; sb.push_back(e);
        tick();
        e = sb.pop_front();
        total++;
        if (b2.out_valid !== 1'b1 || b2.out_data !== e.data || {1'b0, b2.out_ch} !== e.ch) begin
            bad++;
            $display("FAIL manual_sel1: got v=%b d=%b ch=%0d want v=1 d=%b ch=%0d",
                     b2.out_valid, b2.out_data, b2.out_ch, e.data, e.ch);
        end
        $display("txn manual ch=%0d data=%b", b2.out_ch, b2.out_data);
        b2.sel = 1'b0;
        #1;
        total++;
        if (b2.in_ready !== 2'b01) begin
            bad++;
            $display("FAIL manual_ready_sel0: got %b want 01", b2.in_ready);
        end
        e.data = 4'b1010; e.ch = 2'd0; sb.push_back(e);
        tick();
        e = sb.pop_front();
        total++;
        if (b2.out_valid !== 1'b1 || b2.out_data !== e.data || {1'b0, b2.out_ch} !== e.ch) begin
            bad++;
            $display("FAIL manual_sel0: got v=%b d=%b ch=%0d want v=1 d=%b ch=%0d",
                     b2.out_valid, b2.out_data, b2.out_ch, e.data, e.ch);
        end
        $display("txn manual ch=%0d data=%b", b2.out_ch, b2.out_data);
        b2.in_valid = 2'b00;
        tick();
        total++;
        if (b2.out_valid !== 1'b0 || b2.out_data !== 4'b1010) begin
            bad++;
            $display("FAIL manual_drain: got v=%b d=%b want v=0 d=1010", b2.out_valid, b2.out_data);
        end
        $display("txn manual drain");
    endtask

    task automatic test_round_robin();
        exp_t e;
        int   g;
        b4.mode = 1'b1;
        b4.in_data = 16'h4321;
        b4.in_valid = 4'hF;
        b4.out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            g = k % 4;
            #1;
            total++;
            if (b4.in_ready !== onehot4(g)) begin
                bad++;
                $display("FAIL rr_ready_%0d: got %b want %b", k, b4.in_ready, onehot4(g));
            end
            e.data = 4'(g + 1); e.ch = 2'(g); sb.push_back(e);
            tick();
            e = sb.pop_front();
            total++;
            if (b4.out_valid !== 1'b1 || b4.out_data !== e.data || b4.out_ch !== e.ch) begin
                bad++;
                $display("FAIL rr_word_%0d: got v=%b d=%h ch=%0d want v=1 d=%h ch=%0d",
                         k, b4.out_valid, b4.out_data, b4.out_ch, e.data, e.ch);
            end
            $display("txn rr ch=%0d data=%h", b4.out_ch, b4.out_data);
            last_m = g;
        end
        b4.in_valid = 4'h0;
        tick();
    endtask

    task automatic test_sparse();
        exp_t e;
        int   g;
        b4.in_valid = 4'b1001;
        for (int k = 0; k < 3; k++) begin
            g = rr_next(4'b1001, last_m);
            #1;
            total++;
            if (b4.in_ready !== onehot4(g)) begin
                bad++;
                $display("FAIL sparse_ready_%0d: got %b want %b", k, b4.in_ready, onehot4(g));
            end
            e.data = 4'(g + 1); e.ch = 2'(g); sb.push_back(e);
            tick();
            e = sb.pop_front();
            total++;
            if (b4.out_valid !== 1'b1 || b4.out_data !== e.data || b4.out_ch !== e.ch) begin
                bad++;
                $display("FAIL sparse_word_%0d: got v=%b d=%h ch=%0d want v=1 d=%h ch=%0d",
                         k, b4.out_valid, b4.out_data, b4.out_ch, e.data, e.ch);
            end
            $display("txn sparse ch=%0d data=%h", b4.out_ch, b4.out_data);
            last_m = g;
        end
        b4.in_valid = 4'h0;
        tick();
    endtask

    task automatic test_backpressure();
        exp_t e;
        b4.mode = 1'b1;
        b4.in_data = 16'h0700;
        b4.in_valid = 4'b0100;
        b4.out_ready = 1'b0;
        #1;
        total++;
        if (b4.in_ready !== 4'b0100) begin
            bad++;
            $display("FAIL bp_first_ready: got %b want 0100", b4.in_ready);
        end
        e.data = 4'h7; e.ch = 2'd2; sb.push_back(e);
        tick();
        e = sb.pop_front();
        total++;
        if (b4.out_valid !== 1'b1 || b4.out_data !== e.data || b4.out_ch !== e.ch) begin
            bad++;
            $display("FAIL bp_load: got v=%b d=%h ch=%0d want v=1 d=%h ch=%0d",
                     b4.out_valid, b4.out_data, b4.out_ch, e.data, e.ch);
        end
        $display("txn bp ch=%0d data=%h", b4.out_ch, b4.out_data);
        last_m = 2;
        for (int k = 0; k < 5; k++) begin
            total++;
            if (b4.in_ready !== 4'b0000 || b4.out_valid !== 1'b1 || b4.out_data !== 4'h7) begin
                bad++;
                $display("FAIL bp_hold_%0d: got rdy=%b v=%b d=%h want rdy=0000 v=1 d=7",
                         k, b4.in_ready, b4.out_valid, b4.out_data);
            end
            tick();
        end
        b4.in_data = 16'h0900;
        b4.out_ready = 1'b1;
        #1;
        total++;
        if (b4.in_ready !== 4'b0100) begin
            bad++;
            $display("FAIL bp_regrant_ready: got %b want 0100", b4.in_ready);
        end
        e.data = 4'h9; e.ch = 2'd2; sb.push_back(e);
        tick();
        e = sb.pop_front();
        total++;
        if (b4.out_valid !== 1'b1 || b4.out_data !== e.data || b4.out_ch !== e.ch) begin
            bad++;
            $display("FAIL bp_replace: got v=%b d=%h ch=%0d want v=1 d=%h ch=%0d",
                     b4.out_valid, b4.out_data, b4.out_ch, e.data, e.ch);
        end
        $display("txn bp ch=%0d data=%h", b4.out_ch, b4.out_data);
        b4.in_valid = 4'h0;
        tick();
        total++;
        if (b4.out_valid !== 1'b0 || b4.out_data !== 4'h9) begin
            bad++;
            $display("FAIL bp_drain: got v=%b d=%h want v=0 d=9", b4.out_valid, b4.out_data);
        end
    endtask

    task automatic test_invalid_sel();
        exp_t e;
        b3.in_data = 12'h765;
        b3.in_valid = 3'b111;
        b3.mode = 1'b0;
        b3.sel = 2'd0;
        b3.out_ready = 1'b0;
        #1;
        e.data = 4'h5; e.ch = 2'd0; sb.push_back(e);
        tick();
        e = sb.pop_front();
        total++;
        if (b3.out_valid !== 1'b1 || b3.out_data !== e.data || b3.out_ch !== e.ch) begin
            bad++;
            $display("FAIL badsel_preload: got v=%b d=%h ch=%0d want v=1 d=%h ch=%0d",
                     b3.out_valid, b3.out_data, b3.out_ch, e.data, e.ch);
        end
        $display("txn badsel ch=%0d data=%h", b3.out_ch, b3.out_data);
        b3.sel = 2'd3;
        #1;
        total++;
        if (b3.in_ready !== 3'b000) begin
            bad++;
            $display("FAIL badsel_ready_full: got %b want 000", b3.in_ready);
        end
        tick();
        total++;
        if (b3.out_valid !== 1'b1 || b3.out_data !== 4'h5) begin
            bad++;
            $display("FAIL badsel_hold: got v=%b d=%h want v=1 d=5", b3.out_valid, b3.out_data);
        end
        b3.out_ready = 1'b1;
        #1;
        total++;
        if (b3.in_ready !== 3'b000) begin
            bad++;
            $display("FAIL badsel_ready_load: got %b want 000", b3.in_ready);
        end
        tick();
        total++;
        if (b3.out_valid !== 1'b0 || b3.out_data !== 4'h5 || b3.out_ch !== 2'd0) begin
            bad++;
            $display("FAIL badsel_drain: got v=%b d=%h ch=%0d want v=0 d=5 ch=0",
                     b3.out_valid, b3.out_data, b3.out_ch);
        end
        $display("txn badsel drained");
        b3.in_valid = 3'b000;
    endtask

    task automatic test_async_reset();
        exp_t e;
        int   g;
        b4.mode = 1'b1;
        b4.in_data = 16'h4321;
        b4.in_valid = 4'hF;
        b4.out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            g = rr_next(4'hF, last_m);
            #1;
            total++;
            if (b4.in_ready !== onehot4(g)) begin
                bad++;
                $display("FAIL ar_ready_%0d: got %b want %b", k, b4.in_ready, onehot4(g));
            end
            e.data = 4'(g + 1); e.ch = 2'(g); sb.push_back(e);
            tick();
            e = sb.pop_front();
            total++;
            if (b4.out_valid !== 1'b1 || b4.out_data !== e.data || b4.out_ch !== e.ch) begin
                bad++;
                $display("FAIL ar_word_%0d: got v=%b d=%h ch=%0d want v=1 d=%h ch=%0d",
                         k, b4.out_valid, b4.out_data, b4.out_ch, e.data, e.ch);
            end
            $display("txn async ch=%0d data=%h", b4.out_ch, b4.out_data);
            last_m = g;
        end
        #2;
        rst = 1'b1;
        #1;
        total++;
        if (b4.out_valid !== 1'b0 || b4.out_data !== 4'h0 || b4.out_ch !== 2'd0) begin
            bad++;
            $display("FAIL ar_immediate: got v=%b d=%h ch=%0d want v=0 d=0 ch=0",
                     b4.out_valid, b4.out_data, b4.out_ch);
        end
        total++;
        if (b4.in_ready !== 4'b0000) begin
            bad++;
            $display("FAIL ar_in_ready: got %b want 0000", b4.in_ready);
        end
        sb.delete();
        #1;
        rst = 1'b0;
        last_m = 3;
        g = rr_next(4'hF, last_m);
        #1;
        total++;
        if (b4.in_ready !== onehot4(g)) begin
            bad++;
            $display("FAIL ar_first_ready: got %b want %b", b4.in_ready, onehot4(g));
        end
        e.data = 4'(g + 1); e.ch = 2'(g); sb.push_back(e);
        tick();
        e = sb.pop_front();
        total++;
        if (b4.out_valid !== 1'b1 || b4.out_data !== e.data || b4.out_ch !== e.ch) begin
            bad++;
            $display("FAIL ar_first_word: got v=%b d=%h ch=%0d want v=1 d=%h ch=%0d",
                     b4.out_valid, b4.out_data, b4.out_ch, e.data, e.ch);
        end
        $display("txn async ch=%0d data=%h", b4.out_ch, b4.out_data);
        b4.in_valid = 4'h0;
    endtask

    initial begin
        total = 0;
        bad = 0;
        last_m = 3;
        rst = 1'b1;
        b4.in_data = '0; b4.in_valid = '0; b4.mode = 1'b0; b4.sel = '0; b4.out_ready = 1'b0;
        b2.in_data = '0; b2.in_valid = '0; b2.mode = 1'b0; b2.sel = '0; b2.out_ready = 1'b0;
        b3.in_data = '0; b3.in_valid = '0; b3.mode = 1'b0; b3.sel = '0; b3.out_ready = 1'b0;
        test_reset();
        test_manual();
        test_round_robin();
        test_sparse();
        test_backpressure();
        test_invalid_sel();
        test_async_reset();
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_empty: got %0d left want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
